// File: rtl/display_req_if.sv
`default_nettype none
// ============================================================================
// Module   : display_req_if
// Brief    : CPU-to-display request handshake plus completion/collision status.
// Revision : 1.0
// ============================================================================
interface display_req_if;
  logic       req_valid;
  logic       req_ready;
  logic       req_op;
  logic [5:0] req_x;
  logic [4:0] req_y;
  logic [7:0] req_sprite;
  logic       done;
  logic       collision;
  logic       busy;

  modport master (
    output req_valid, req_op, req_x, req_y, req_sprite,
    input  req_ready, done, collision, busy
  );

  modport slave (
    input  req_valid, req_op, req_x, req_y, req_sprite,
    output req_ready, done, collision, busy
  );
endinterface
`default_nettype wire

// File: rtl/display_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : display_scheduler
// Brief    : Owns the 64x32 CHIP-8 bitmap; applies CLS / DRW-row requests as XOR updates.
// Revision : 1.0
// ============================================================================
module display_scheduler #(
  parameter bit VBLANK_SYNC = 1'b1,
  parameter bit WRAP_X      = 1'b1
) (
  input  logic              pixel_clk_7_425mhz,
  input  logic              rst,
  input  logic              in_vblank,
  display_req_if.slave      req,
  output logic [31:0][63:0] display
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WAIT_VB = 3'd1,
    CLEAR   = 3'd2,
    DRAW    = 3'd3,
    DONE    = 3'd4
  } state_t;

  state_t      r_state;
  logic        r_op;
  logic [5:0]  r_x;
  logic [4:0]  r_y;
  logic [7:0]  r_sprite;
  logic [4:0]  r_row;
  logic        r_done;
  logic        r_collision;

  logic [63:0] w_base;
  logic [63:0] w_mask;
  logic [63:0] w_row;
  logic [63:0] w_hit;

  assign w_base = {r_sprite, 56'b0};

  generate
    if (WRAP_X) begin : g_wrap
      // Shifting a 64-bit value by 64 yields zero, so x=0 needs no special case.
      assign w_mask = (w_base >> r_x) | (w_base << (7'd64 - {1'b0, r_x}));
    end else begin : g_clip
      assign w_mask = w_base >> r_x;
    end
  endgenerate

  assign w_row = display[r_y];
  assign w_hit = w_row & w_mask;

  assign req.req_ready = (r_state == IDLE);
  assign req.busy      = (r_state != IDLE);
  assign req.done      = r_done;
  assign req.collision = r_collision;

  always_ff @(posedge pixel_clk_7_425mhz or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_op        <= 1'b0;
      r_x         <= 6'd0;
      r_y         <= 5'd0;
      r_sprite    <= 8'd0;
      r_row       <= 5'd0;
      r_done      <= 1'b0;
      r_collision <= 1'b0;
      display     <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (req.req_valid) begin
            r_op     <= req.req_op;
            r_x      <= req.req_x;
            r_y      <= req.req_y;
            r_sprite <= req.req_sprite;
            r_row    <= 5'd0;
            if (VBLANK_SYNC && !in_vblank) begin
              r_state <= WAIT_VB;
            end else begin
              r_state <= req.req_op ? CLEAR : DRAW;
            end
          end
        end
        WAIT_VB: begin
          if (in_vblank) begin
            r_state <= r_op ? CLEAR : DRAW;
          end
        end
        CLEAR: begin
          display[r_row] <= 64'd0;
          r_row          <= r_row + 5'd1;
          if (r_row == 5'd31) begin
            r_state     <= DONE;
            r_done      <= 1'b1;
            r_collision <= 1'b0;
          end
        end
        DRAW: begin
          display[r_y] <= w_row ^ w_mask;
          r_collision  <= |w_hit;
          r_done       <= 1'b1;
          r_state      <= DONE;
        end
        DONE: begin
          r_done  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_display_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_display_scheduler
// Brief    : Directed self-checking bench; three instances cover the parameter corners.
// Revision : 1.0
// ============================================================================
module tb_display_scheduler;

  logic clk = 1'b0;
  logic rst;
  logic vb_c;
  int   total = 0;
  int   bad   = 0;

  logic [31:0][63:0] disp_a, disp_b, disp_c;
  logic [31:0][63:0] exp_disp;

  always #5 clk = ~clk;

  display_req_if ifa ();
  display_req_if ifb ();
  display_req_if ifc ();

  display_scheduler #(.VBLANK_SYNC(1'b0), .WRAP_X(1'b1)) dut_a (
    .pixel_clk_7_425mhz(clk), .rst(rst), .in_vblank(1'b0), .req(ifa), .display(disp_a));
  display_scheduler #(.VBLANK_SYNC(1'b0), .WRAP_X(1'b0)) dut_b (
    .pixel_clk_7_425mhz(clk), .rst(rst), .in_vblank(1'b0), .req(ifb), .display(disp_b));
  display_scheduler #(.VBLANK_SYNC(1'b1), .WRAP_X(1'b1)) dut_c (
    .pixel_clk_7_425mhz(clk), .rst(rst), .in_vblank(vb_c), .req(ifc), .display(disp_c));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_a(input logic op, input logic [5:0] x, input logic [4:0] y, input logic [7:0] s);
    ifa.req_valid = 1'b1; ifa.req_op = op; ifa.req_x = x; ifa.req_y = y; ifa.req_sprite = s;
  endtask

  task automatic set_b(input logic op, input logic [5:0] x, input logic [4:0] y, input logic [7:0] s);
    ifb.req_valid = 1'b1; ifb.req_op = op; ifb.req_x = x; ifb.req_y = y; ifb.req_sprite = s;
  endtask

  task automatic set_c(input logic op, input logic [5:0] x, input logic [4:0] y, input logic [7:0] s);
    ifc.req_valid = 1'b1; ifc.req_op = op; ifc.req_x = x; ifc.req_y = y; ifc.req_sprite = s;
  endtask

  function automatic int first_diff(input logic [31:0][63:0] a, input logic [31:0][63:0] b);
    for (int r = 0; r < 32; r++) if (a[r] !== b[r]) return r;
    return 0;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    int  fd;
    logic saw_done;
    do_reset();
    total++; if (disp_a !== '0) begin bad++; fd = first_diff(disp_a, '0);
      $display("FAIL reset_display: row %0d got %h want 0", fd, disp_a[fd]); end
    total++; if (ifa.req_ready !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b want 1", ifa.req_ready); end
    total++; if (ifa.done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", ifa.done); end
    total++; if (ifa.collision !== 1'b0) begin bad++; $display("FAIL reset_collision: got %b want 0", ifa.collision); end
    total++; if (ifa.busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", ifa.busy); end
    // Light row 20 so a CLEAR aborted at row 10 would visibly leave it lit.
    set_a(1'b0, 6'd0, 5'd20, 8'hFF);
    tick(); ifa.req_valid = 1'b0; tick(); tick();
    total++; if (disp_a[20] !== 64'hFF00_0000_0000_0000) begin bad++;
      $display("FAIL reset_predraw: got %h want %h", disp_a[20], 64'hFF00_0000_0000_0000); end
    set_a(1'b1, 6'd0, 5'd0, 8'h00);
    tick(); ifa.req_valid = 1'b0;
    repeat (10) tick();
    total++; if (disp_a[20] !== 64'hFF00_0000_0000_0000 || ifa.busy !== 1'b1) begin bad++;
      $display("FAIL reset_midclear: row20 %h busy %b want ff00000000000000 busy 1", disp_a[20], ifa.busy); end
    #2 rst = 1'b1;
    #1;
    total++; if (disp_a !== '0) begin bad++; fd = first_diff(disp_a, '0);
      $display("FAIL reset_async_display: row %0d got %h want 0", fd, disp_a[fd]); end
    total++; if (ifa.req_ready !== 1'b1) begin bad++; $display("FAIL reset_async_ready: got %b want 1", ifa.req_ready); end
    tick();
    rst = 1'b0;
    saw_done = 1'b0;
    for (int i = 0; i < 40; i++) begin tick(); if (ifa.done) saw_done = 1'b1; end
    total++; if (saw_done !== 1'b0) begin bad++; $display("FAIL reset_no_done: got %b want 0", saw_done); end
  endtask

  task automatic test_draw();
    set_a(1'b0, 6'd0, 5'd0, 8'hF0);
    tick(); ifa.req_valid = 1'b0;
    total++; if (ifa.busy !== 1'b1 || ifa.done !== 1'b0 || disp_a[0] !== 64'd0) begin bad++;
      $display("FAIL draw_e0: busy %b done %b row %h want busy 1 done 0 row 0", ifa.busy, ifa.done, disp_a[0]); end
    tick();
    total++; if (disp_a[0] !== 64'hF000_0000_0000_0000) begin bad++;
      $display("FAIL draw_row: got %h want %h", disp_a[0], 64'hF000_0000_0000_0000); end
    total++; if (ifa.done !== 1'b1 || ifa.collision !== 1'b0) begin bad++;
      $display("FAIL draw_done: done %b coll %b want done 1 coll 0", ifa.done, ifa.collision); end
    tick();
    total++; if (ifa.done !== 1'b0 || ifa.req_ready !== 1'b1) begin bad++;
      $display("FAIL draw_e2: done %b ready %b want done 0 ready 1", ifa.done, ifa.req_ready); end
    set_a(1'b0, 6'd0, 5'd0, 8'hF0);
    tick(); ifa.req_valid = 1'b0;
    tick();
    total++; if (disp_a[0] !== 64'd0 || ifa.collision !== 1'b1 || ifa.done !== 1'b1) begin bad++;
      $display("FAIL draw_repeat: row %h coll %b done %b want row 0 coll 1 done 1", disp_a[0], ifa.collision, ifa.done); end
    tick();
    total++; if (ifa.collision !== 1'b1) begin bad++; $display("FAIL draw_coll_hold: got %b want 1", ifa.collision); end
  endtask

  task automatic test_wrap();
    set_a(1'b0, 6'd60, 5'd31, 8'hFF);
    set_b(1'b0, 6'd60, 5'd31, 8'hFF);
    tick(); ifa.req_valid = 1'b0; ifb.req_valid = 1'b0;
    tick();
    total++; if (disp_a[31] !== 64'hF000_0000_0000_000F) begin bad++;
      $display("FAIL wrap_on: got %h want %h", disp_a[31], 64'hF000_0000_0000_000F); end
    total++; if (disp_b[31] !== 64'h0000_0000_0000_000F) begin bad++;
      $display("FAIL wrap_off: got %h want %h", disp_b[31], 64'h0000_0000_0000_000F); end
    total++; if (disp_a[30] !== 64'd0 || ifa.collision !== 1'b0) begin bad++;
      $display("FAIL wrap_side: row30 %h coll %b want 0 0", disp_a[30], ifa.collision); end
    tick();
  endtask

  task automatic test_vblank();
    vb_c = 1'b0;
    set_c(1'b0, 6'd8, 5'd5, 8'hAA);
    tick(); ifc.req_valid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      total++; if (disp_c[5] !== 64'd0 || ifc.busy !== 1'b1) begin bad++;
        $display("FAIL vb_wait%0d: row %h busy %b want 0 1", i, disp_c[5], ifc.busy); end
      tick();
    end
    vb_c = 1'b1;
    tick();
    total++; if (disp_c[5] !== 64'd0 || ifc.busy !== 1'b1 || ifc.done !== 1'b0) begin bad++;
      $display("FAIL vb_seen: row %h busy %b done %b want 0 1 0", disp_c[5], ifc.busy, ifc.done); end
    tick();
    total++; if (disp_c[5] !== 64'h00AA_0000_0000_0000 || ifc.done !== 1'b1) begin bad++;
      $display("FAIL vb_update: row %h done %b want %h 1", disp_c[5], ifc.done, 64'h00AA_0000_0000_0000); end
    vb_c = 1'b0;
    tick();
    total++; if (ifc.req_ready !== 1'b1) begin bad++; $display("FAIL vb_idle: got %b want 1", ifc.req_ready); end
  endtask

  task automatic test_clear();
    int   fd;
    logic got;
    do_reset();
    for (int y = 0; y < 32; y++) begin
      for (int x = 0; x < 64; x += 8) begin
        set_a(1'b0, 6'(x), 5'(y), 8'hFF);
        tick(); ifa.req_valid = 1'b0; tick(); tick();
      end
    end
    exp_disp = '1;
    total++; if (disp_a !== exp_disp) begin bad++; fd = first_diff(disp_a, exp_disp);
      $display("FAIL clear_fill: row %0d got %h want %h", fd, disp_a[fd], exp_disp[fd]); end
    set_a(1'b0, 6'd4, 5'd0, 8'hFF);
    tick(); ifa.req_valid = 1'b0; tick();
    exp_disp[0] = 64'hF00F_FFFF_FFFF_FFFF;
    total++; if (disp_a[0] !== exp_disp[0] || ifa.collision !== 1'b1) begin bad++;
      $display("FAIL clear_precoll: row %h coll %b want %h 1", disp_a[0], ifa.collision, exp_disp[0]); end
    tick();
    set_a(1'b1, 6'd0, 5'd0, 8'h00);
    tick();
    for (int k = 1; k <= 32; k++) begin
      tick();
      exp_disp[k-1] = 64'd0;
      total++; if (disp_a !== exp_disp) begin bad++; fd = first_diff(disp_a, exp_disp);
        $display("FAIL clear_row%0d: row %0d got %h want %h", k, fd, disp_a[fd], exp_disp[fd]); end
      total++; if (ifa.done !== (k == 32) || ifa.req_ready !== 1'b0) begin bad++;
        $display("FAIL clear_ctl%0d: done %b ready %b want %b 0", k, ifa.done, ifa.req_ready, (k == 32)); end
    end
    total++; if (ifa.collision !== 1'b0) begin bad++; $display("FAIL clear_coll: got %b want 0", ifa.collision); end
    tick();
    total++; if (ifa.req_ready !== 1'b1 || ifa.busy !== 1'b0 || ifa.done !== 1'b0) begin bad++;
      $display("FAIL clear_idle: ready %b busy %b done %b want 1 0 0", ifa.req_ready, ifa.busy, ifa.done); end
    tick();
    ifa.req_valid = 1'b0;
    total++; if (ifa.busy !== 1'b1) begin bad++; $display("FAIL clear_reaccept: got %b want 1", ifa.busy); end
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin tick(); if (ifa.done) got = 1'b1; end
    total++; if (got !== 1'b1) begin bad++; $display("FAIL clear_timeout: done %b want 1", got); end
    tick();
  endtask

  task automatic test_back_to_back();
    set_a(1'b0, 6'd0, 5'd1, 8'h81);
    tick();
    total++; if (ifa.busy !== 1'b1) begin bad++; $display("FAIL b2b_acc1: got %b want 1", ifa.busy); end
    set_a(1'b0, 6'd3, 5'd1, 8'hFF);
    tick();
    total++; if (disp_a[1] !== 64'h8100_0000_0000_0000 || ifa.done !== 1'b1) begin bad++;
      $display("FAIL b2b_row1: row %h done %b want %h 1", disp_a[1], ifa.done, 64'h8100_0000_0000_0000); end
    set_a(1'b0, 6'd16, 5'd2, 8'h3C);
    tick();
    total++; if (ifa.req_ready !== 1'b1 || disp_a[1] !== 64'h8100_0000_0000_0000) begin bad++;
      $display("FAIL b2b_gap: ready %b row1 %h want 1 %h", ifa.req_ready, disp_a[1], 64'h8100_0000_0000_0000); end
    tick();
    total++; if (ifa.busy !== 1'b1) begin bad++; $display("FAIL b2b_acc2: got %b want 1", ifa.busy); end
    set_a(1'b0, 6'd40, 5'd3, 8'hC3);
    tick();
    total++; if (disp_a[2] !== 64'h0000_3C00_0000_0000 || disp_a[1] !== 64'h8100_0000_0000_0000 || ifa.done !== 1'b1) begin bad++;
      $display("FAIL b2b_row2: row2 %h row1 %h done %b want %h %h 1", disp_a[2], disp_a[1], ifa.done,
               64'h0000_3C00_0000_0000, 64'h8100_0000_0000_0000); end
    tick();
    tick();
    ifa.req_valid = 1'b0;
    total++; if (ifa.busy !== 1'b1) begin bad++; $display("FAIL b2b_acc3: got %b want 1", ifa.busy); end
    tick();
    total++; if (disp_a[3] !== 64'h0000_0000_00C3_0000 || ifa.done !== 1'b1) begin bad++;
      $display("FAIL b2b_row3: row %h done %b want %h 1", disp_a[3], ifa.done, 64'h0000_0000_00C3_0000); end
    tick();
  endtask

  initial begin
    rst = 1'b1;
    vb_c = 1'b0;
    ifa.req_valid = 1'b0; ifa.req_op = 1'b0; ifa.req_x = 6'd0; ifa.req_y = 5'd0; ifa.req_sprite = 8'd0;
    ifb.req_valid = 1'b0; ifb.req_op = 1'b0; ifb.req_x = 6'd0; ifb.req_y = 5'd0; ifb.req_sprite = 8'd0;
    ifc.req_valid = 1'b0; ifc.req_op = 1'b0; ifc.req_x = 6'd0; ifc.req_y = 5'd0; ifc.req_sprite = 8'd0;
    test_reset();
    test_draw();
    test_wrap();
    test_vblank();
    test_clear();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
